alu_cdb_arbiter: RTL and testbench

Round-robin arbiter that shares the single common-data-bus (CDB) write port into the ROB between the ALU reservation-station entries whose operands are ready. Each cycle it grants at most one requesting entry, so that entry may free itself. It captures the grantee's result and ROB tag into an output register and presents them to the ROB under a valid/ready handshake. It sits between the ALU reservation station's per-entry done/result vectors and the ROB write port.

---
 rtl/alu_cdb_arbiter.sv | 141 ++++++++++++++
 tb/tb_alu_cdb_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cdb_arbiter.sv
// alu_cdb_arbiter
// ---------------------------------------------------------------------------
// Purpose: shares the single CDB write port into the ROB among the ALU
// reservation-station entries that have a finished result. Each cycle at most
// one requesting entry is granted, using a round-robin search that starts at
// rr_ptr. The grantee's result and ROB tag are captured into an output
// register that is offered to the ROB.
//
// Handshake (CDB side): a beat is transferred on every cycle where cdb_valid
// and cdb_ready are both 1. While cdb_valid=1 and cdb_ready=0 the beat is
// held unchanged. cdb_valid never drops without a transfer, except on flush
// or rst. The request side has no ready signal: a grant in cycle t means the
// entry's data was taken at the end of cycle t, and the entry drops req
// from t+1.
//
// Ports:
//   clk, rst      clock; synchronous active-high reset
//   req           per-entry request (entry holds a valid result)
//   req_data      per-entry 32-bit ALU result
//   req_tag       per-entry destination ROB index
//   flush         discard the held beat and suppress any grant this cycle
//   cdb_ready     ROB accepts the current beat
//   grant         one-hot combinational grant (0 when none)
//   grant_idx     binary index of grant (0 when none)
//   cdb_valid     registered beat valid
//   cdb_tag       registered ROB index of the beat
//   cdb_data      registered result of the beat
//   stall_cycles  saturating count of cycles with cdb_valid=1, cdb_ready=0
// ---------------------------------------------------------------------------
module alu_cdb_arbiter #(
    parameter int NUM_REQ      = 8,
    parameter int REQ_IDX_BITS = 3,
    parameter int ROB_IDX_BITS = 4
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [NUM_REQ-1:0]                     req,
    input  logic [NUM_REQ-1:0][31:0]               req_data,
    input  logic [NUM_REQ-1:0][ROB_IDX_BITS-1:0]   req_tag,
    input  logic                                   flush,
    input  logic                                   cdb_ready,
    output logic [NUM_REQ-1:0]                     grant,
    output logic [REQ_IDX_BITS-1:0]                grant_idx,
    output logic                                   cdb_valid,
    output logic [ROB_IDX_BITS-1:0]                cdb_tag,
    output logic [31:0]                            cdb_data,
    output logic [31:0]                            stall_cycles
);

    localparam int PW = REQ_IDX_BITS + 1;

    logic                    cdb_valid_q, cdb_valid_d;
    logic [ROB_IDX_BITS-1:0] cdb_tag_q, cdb_tag_d;
    logic [31:0]             cdb_data_q, cdb_data_d;
    logic [REQ_IDX_BITS-1:0] rr_ptr_q, rr_ptr_d;
    logic [31:0]             stall_cycles_q, stall_cycles_d;

    logic                    can_load;
    logic                    arb_en;
    logic                    grant_any;
    logic [PW-1:0]           cand_w;
    logic [REQ_IDX_BITS-1:0] cand;

    // The output register can take a new beat when it is empty or when its
    // current beat leaves this cycle (pass-through on drain).
    assign can_load = ~cdb_valid_q | cdb_ready;
    assign arb_en   = can_load & ~flush & ~rst;

    // Round-robin search: candidate i is (rr_ptr + i) mod NUM_REQ; the first
    // requesting candidate wins. The wider sum keeps the wrap correct even
    // when NUM_REQ is not a power of two.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        cand_w    = '0;
        cand      = '0;
        if (arb_en) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                cand_w = {1'b0, rr_ptr_q} + PW'(i);
                if (cand_w >= PW'(NUM_REQ)) begin
                    cand_w = cand_w - PW'(NUM_REQ);
                end
                cand = cand_w[REQ_IDX_BITS-1:0];
                if (!grant_any && req[cand]) begin
                    grant_any   = 1'b1;
                    grant[cand] = 1'b1;
                    grant_idx   = cand;
                end
            end
        end
    end

    // Next-state for the output register, pointer and stall counter.
    always_comb begin
        cdb_valid_d    = cdb_valid_q;
        cdb_tag_d      = cdb_tag_q;
        cdb_data_d     = cdb_data_q;
        rr_ptr_d       = rr_ptr_q;
        stall_cycles_d = stall_cycles_q;

        if (flush) begin
            cdb_valid_d = 1'b0;
        end else if (grant_any) begin
            cdb_valid_d = 1'b1;
            cdb_tag_d   = req_tag[grant_idx];
            cdb_data_d  = req_data[grant_idx];
            rr_ptr_d    = (grant_idx == REQ_IDX_BITS'(NUM_REQ - 1)) ? '0
                                                                    : grant_idx + 1'b1;
        end else if (cdb_ready) begin
            // Beat accepted with nothing to replace it; tag/data keep their value.
            cdb_valid_d = 1'b0;
        end

        if (cdb_valid_q && !cdb_ready && !flush && (stall_cycles_q != 32'hFFFF_FFFF)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cdb_valid_q    <= 1'b0;
            cdb_tag_q      <= '0;
            cdb_data_q     <= '0;
            rr_ptr_q       <= '0;
            stall_cycles_q <= '0;
        end else begin
            cdb_valid_q    <= cdb_valid_d;
            cdb_tag_q      <= cdb_tag_d;
            cdb_data_q     <= cdb_data_d;
            rr_ptr_q       <= rr_ptr_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign cdb_valid    = cdb_valid_q;
    assign cdb_tag      = cdb_tag_q;
    assign cdb_data     = cdb_data_q;
    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_alu_cdb_arbiter.sv
// tb_alu_cdb_arbiter
// Bench for alu_cdb_arbiter: directed scenarios followed by randomized
// traffic. A behavioural model tracks the expected beat, round-robin position
// and stall count; a queue holds beats the ROB is expected to receive.
module tb_alu_cdb_arbiter;

    localparam int N  = 8;
    localparam int IB = 3;
    localparam int TB = 4;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [N-1:0]          req;
    logic [N-1:0][31:0]    req_data;
    logic [N-1:0][TB-1:0]  req_tag;
    logic                  flush;
    logic                  cdb_ready;
    logic [N-1:0]          grant;
    logic [IB-1:0]         grant_idx;
    logic                  cdb_valid;
    logic [TB-1:0]         cdb_tag;
    logic [31:0]           cdb_data;
    logic [31:0]           stall_cycles;

    alu_cdb_arbiter #(.NUM_REQ(N), .REQ_IDX_BITS(IB), .ROB_IDX_BITS(TB)) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_tag(req_tag),
        .flush(flush), .cdb_ready(cdb_ready), .grant(grant), .grant_idx(grant_idx),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .stall_cycles(stall_cycles)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard / model state ----------------
    int total = 0;
    int bad   = 0;

    bit               m_valid;
    logic [TB-1:0]    m_tag;
    logic [31:0]      m_data;
    int               m_ptr;
    longint           m_stall;
    int               last_g;
    int               wait_cnt[N];
    logic [TB+31:0]   exp_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Who should win this cycle: the first requester found walking upward
    // (with wrap) from the round-robin position, if the output has room.
    function automatic int pick();
        int j;
        if (rst || flush || (m_valid && !cdb_ready)) return -1;
        for (int k = 0; k < N; k++) begin
            j = (m_ptr + k) % N;
            if (req[j]) return j;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_tag = '0; m_data = '0; m_ptr = 0; m_stall = 0; last_g = -1;
        exp_q.delete();
        for (int k = 0; k < N; k++) wait_cnt[k] = 0;
    endtask

    // One clock: check at the falling edge, advance the model, then return
    // 1 ns after the rising edge so the caller can drive the next inputs.
    task automatic cycle();
        int g;
        logic [TB+31:0] beat;
        @(negedge clk);
        g = pick();
        check("grant", 64'(grant), (g < 0) ? 64'd0 : (64'd1 << g));
        check("grant_idx", 64'(grant_idx), (g < 0) ? 64'd0 : 64'(g));
        check("cdb_valid", 64'(cdb_valid), 64'(m_valid));
        check("cdb_tag", 64'(cdb_tag), 64'(m_tag));
        check("cdb_data", 64'(cdb_data), 64'(m_data));
        check("stall_cycles", 64'(stall_cycles), 64'(m_stall));

        if (!rst && !flush && m_valid && cdb_ready) begin
            if (exp_q.size() == 0) begin
                check("rob_beat_unexpected", 64'(1), 64'(0));
            end else begin
                beat = exp_q.pop_front();
                check("rob_beat", {28'd0, cdb_tag, cdb_data}, 64'(beat));
            end
        end

        if (rst) begin
            model_reset();
        end else begin
            if (m_valid && !cdb_ready && !flush && m_stall != 64'hFFFF_FFFF) m_stall++;
            if (flush) begin
                m_valid = 0;
                exp_q.delete();
            end else if (g >= 0) begin
                m_valid = 1;
                m_tag   = req_tag[g];
                m_data  = req_data[g];
                m_ptr   = (g + 1) % N;
                exp_q.push_back({req_tag[g], req_data[g]});
                check("fairness", 64'(wait_cnt[g] < N), 64'd1);
                for (int k = 0; k < N; k++) begin
                    if (k == g) wait_cnt[k] = 0;
                    else if (req[k]) wait_cnt[k]++;
                end
            end else if (cdb_ready) begin
                m_valid = 0;
            end
            for (int k = 0; k < N; k++) if (!req[k]) wait_cnt[k] = 0;
        end
        last_g = g;
        @(posedge clk);
        #1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_idle();
        req = '0; flush = 0; cdb_ready = 1;
        for (int k = 0; k < N; k++) begin
            req_data[k] = 32'(k);
            req_tag[k]  = TB'(k);
        end
    endtask

    // Contract-respecting requesters: a granted entry drops its request,
    // others keep theirs stable, idle entries occasionally raise a new one.
    task automatic drive_random();
        if (last_g >= 0) req[last_g] = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!req[k] && $urandom_range(2, 0) == 0) begin
                req[k]      = 1'b1;
                req_data[k] = $urandom;
                req_tag[k]  = TB'($urandom_range(15, 0));
            end
        end
        cdb_ready = ($urandom_range(3, 0) != 0);
        flush     = ($urandom_range(39, 0) == 0);
        rst       = ($urandom_range(299, 0) == 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        model_reset();
        drive_idle();
        rst = 1;
        #1;
        cycle();
        req = 8'h01;          // a request during reset must not be granted
        cycle();
        rst = 0;

        // Single request, first beat.
        req = 8'h01; req_data[0] = 32'h11; req_tag[0] = 4'd3;
        cycle();
        req = '0;
        check("first_valid", 64'(cdb_valid), 64'd1);
        check("first_tag", 64'(cdb_tag), 64'd3);
        check("first_data", 64'(cdb_data), 64'h11);

        // Round-robin sweep with every entry requesting.
        req = 8'hFF;
        for (int k = 0; k < N; k++) begin req_data[k] = 32'(k); req_tag[k] = TB'(k); end
        for (int c = 0; c < 9; c++) cycle();
        req = '0;

        // Backpressure: load a beat, then hold it for 5 cycles.
        req = 8'h01; req_data[0] = 32'hA5A5; cycle();
        cdb_ready = 0; req = 8'h04; req_data[2] = 32'hC0DE; req_tag[2] = 4'd9;
        for (int c = 0; c < 5; c++) cycle();
        check("bp_stall", 64'(stall_cycles), 64'd5);
        check("bp_data_held", 64'(cdb_data), 64'hA5A5);
        cdb_ready = 1;
        cycle();
        req = '0;
        check("bp_release_data", 64'(cdb_data), 64'hC0DE);

        // Wrap: steer rr_ptr to 6, then 0x42 wins at 6 and 0x02 follows.
        req = 8'h20; cycle();
        req = 8'h42; cycle();
        check("wrap_grant6", 64'(cdb_data), 64'(req_data[6]));
        req = 8'h02; cycle();
        check("wrap_grant1", 64'(cdb_data), 64'(req_data[1]));

        // Flush while a beat is stalled.
        cdb_ready = 0; req = 8'h08; flush = 1; cycle();
        flush = 0;
        check("flush_valid", 64'(cdb_valid), 64'd0);
        cycle();              // grant to entry 3 expected here
        req = '0; cdb_ready = 1; cycle();

        // Reset in the middle of a stall.
        req = 8'h01; cycle();
        req = '0; cdb_ready = 0;
        for (int c = 0; c < 3; c++) cycle();
        rst = 1; req = 8'h10; cycle();
        rst = 0;
        check("rst_valid", 64'(cdb_valid), 64'd0);
        check("rst_stall", 64'(stall_cycles), 64'd0);
        req = 8'h81; cdb_ready = 1; cycle();   // pointer back at 0: entry 0 wins
        check("rst_ptr_grant0", 64'(cdb_tag), 64'(req_tag[0]));
        req = '0; cycle();

        // Randomized traffic.
        last_g = -1;
        for (int c = 0; c < 3000; c++) begin
            drive_random();
            cycle();
        end
        rst = 0; flush = 0; req = '0; cdb_ready = 1;
        cycle();
        cycle();
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
